a2d_chnl_seq: RTL and testbench

- Sits directly downstream of A2D_intf and drives its conversion handshake (strt_cnv, chnnl, cnv_cmplt, res).
- Sweeps round-robin over a masked set of the 8 ADC128S channels and averages 2^AVG_LOG2 conversions per channel.
- Undoes the A2D inversion and stores one 12-bit result per channel in a register file read by downstream logic.
- Reports per-channel valid flags, a sweep-complete pulse and a sticky timeout error.

---
 rtl/a2d_chnl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_a2d_chnl_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_chnl_seq.sv
// a2d_chnl_seq: round-robin conversion sequencer for the A2D_intf / ADC128S path.
// Sweeps the channels selected by chnl_mask from lowest to highest and averages
// 2^AVG_LOG2 conversions per channel. It undoes the A2D data inversion and stores
// one 12-bit result per channel in a small register file.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          start sweeps (sampled in IDLE only)
//   chnl_mask   channels to convert, latched at sweep start
//   err_clr     clears the sticky timeout flag
//   rd_chnl     read address, rd_data is the combinational read of the result file
//   valid       per-channel "result written" flags
//   sweep_done  one-cycle pulse at the end of each sweep
//   err         sticky conversion timeout flag
//   strt_cnv    one-cycle conversion request to A2D_intf
//   chnnl       channel for the conversion, held until completion
//   cnv_cmplt   completion level from A2D_intf, res is its inverted result
module a2d_chnl_seq #(
  parameter int AVG_LOG2  = 2,
  parameter int SWEEP_GAP = 1024,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  chnl_mask,
  input  logic        err_clr,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic [7:0]  valid,
  output logic        sweep_done,
  output logic        err,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int GAP_W = $clog2(SWEEP_GAP + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] NUM_SAMP = CNT_W'(32'd1 << AVG_LOG2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SWEEP_GAP - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  state_t             state_r, state_nxt;
  logic [7:0]         mask_q_r;
  logic [2:0]         chnnl_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   samp_cnt_r;
  logic [TMR_W-1:0]   tmr_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               cnv_cmplt_q_r;
  logic               strt_cnv_r;
  logic               sweep_done_r;
  logic               err_r;
  logic [7:0]         valid_r;
  logic [11:0]        regs_r [8];

  logic               cmplt_edge_s;
  logic               last_samp_s;
  logic               timeout_s;
  logic [7:0]         above_s;
  logic [7:0]         higher_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic [11:0]        avg_s;

  // Completion is the rising edge of the registered cnv_cmplt level.
  assign cmplt_edge_s = cnv_cmplt & ~cnv_cmplt_q_r;
  assign last_samp_s  = (samp_cnt_r + CNT_W'(1)) == NUM_SAMP;
  assign timeout_s    = (state_r == WAIT) && !cmplt_edge_s && (tmr_r == TMR_LAST);
  // Channels of the latched mask strictly above the current one.
  assign above_s      = 8'hFE << chnnl_r;
  assign higher_s     = mask_q_r & above_s;
  // res arrives inverted from A2D_intf; re-invert before accumulating.
  assign acc_sum_s    = acc_r + ACC_W'(~res);
  assign avg_s        = 12'(acc_sum_s >> AVG_LOG2);

  assign rd_data    = regs_r[rd_chnl];
  assign valid      = valid_r;
  assign sweep_done = sweep_done_r;
  assign err        = err_r;
  assign strt_cnv   = strt_cnv_r;
  assign chnnl      = chnnl_r;

  // Next-state logic of the sweep sequencer.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (en && (chnl_mask != 8'h00)) state_nxt = START;
        else                            state_nxt = IDLE;
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (cmplt_edge_s) begin
          if (last_samp_s) state_nxt = NEXT;
          else             state_nxt = START;
        end else if (tmr_r == TMR_LAST) begin
          state_nxt = NEXT;
        end else begin
          state_nxt = WAIT;
        end
      end
      NEXT: begin
        if (higher_s != 8'h00) state_nxt = START;
        else                   state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt = IDLE;
        else                       state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnv_cmplt_q_r <= 1'b0;
      strt_cnv_r    <= 1'b0;
      sweep_done_r  <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      cnv_cmplt_q_r <= cnv_cmplt;
      // High exactly during the single START cycle.
      strt_cnv_r    <= (state_nxt == START);
      // Looked ahead so the pulse lines up with the final NEXT cycle.
      sweep_done_r  <= (state_r == WAIT) && (state_nxt == NEXT) && (higher_s == 8'h00);
      // A timeout beats a simultaneous clear.
      if (timeout_s)    err_r <= 1'b1;
      else if (err_clr) err_r <= 1'b0;
      else              err_r <= err_r;
    end
  end

  // Channel selection, accumulator, sample count and timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q_r   <= 8'h00;
      chnnl_r    <= 3'd0;
      acc_r      <= '0;
      samp_cnt_r <= '0;
      tmr_r      <= '0;
      gap_cnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (state_nxt == START) begin
            mask_q_r   <= chnl_mask;
            chnnl_r    <= lowest_bit(chnl_mask);
            acc_r      <= '0;
            samp_cnt_r <= '0;
          end
        end
        START: tmr_r <= '0;
        WAIT: begin
          if (cmplt_edge_s) begin
            acc_r      <= acc_sum_s;
            samp_cnt_r <= samp_cnt_r + CNT_W'(1);
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        NEXT: begin
          if (higher_s != 8'h00) begin
            chnnl_r    <= lowest_bit(higher_s);
            acc_r      <= '0;
            samp_cnt_r <= '0;
          end else begin
            gap_cnt_r <= '0;
          end
        end
        GAP: gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Result file and valid flags, written when a channel's last sample lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 8'h00;
      for (int i = 0; i < 8; i++) regs_r[i] <= 12'h000;
    end else if ((state_r == WAIT) && cmplt_edge_s && last_samp_s) begin
      regs_r[chnnl_r]  <= avg_s;
      valid_r[chnnl_r] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_a2d_chnl_seq.sv
// Directed bench for a2d_chnl_seq with a simple A2D_intf responder model.
module tb_a2d_chnl_seq;

  localparam int AVG_LOG2  = 2;
  localparam int SWEEP_GAP = 16;
  localparam int TIMEOUT   = 64;
  localparam int LAT       = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  chnl_mask;
  logic        err_clr;
  logic [2:0]  rd_chnl;
  logic [11:0] rd_data;
  logic [7:0]  valid;
  logic        sweep_done;
  logic        err;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder / monitor state
  logic        mon_clr = 1'b0;
  logic [7:0]  suppress = 8'h00;
  int          strt_cnt = 0;
  int          sd_cnt = 0;
  int          stab_err = 0;
  logic [31:0] order = 32'h0;
  logic        pend = 1'b0;
  int          cd = 0;
  logic [2:0]  cur_ch = 3'd0;
  logic [2:0]  last_ch = 3'd0;
  int          samp_idx = 0;
  logic [11:0] cur_val = 12'h000;
  logic [11:0] base [8] = '{12'h100, 12'h7F0, 12'h234, 12'hABC,
                            12'h011, 12'hFF0, 12'h555, 12'h0A0};

  a2d_chnl_seq #(.AVG_LOG2(AVG_LOG2), .SWEEP_GAP(SWEEP_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .chnl_mask(chnl_mask), .err_clr(err_clr),
    .rd_chnl(rd_chnl), .rd_data(rd_data), .valid(valid), .sweep_done(sweep_done),
    .err(err), .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
  );

  always #5 clk = ~clk;

  // A2D_intf stand-in: LAT cycles after strt_cnv it raises cnv_cmplt with inverted data.
  always @(negedge clk) begin
    if (mon_clr) begin
      strt_cnt = 0; sd_cnt = 0; stab_err = 0; order = 32'h0;
    end else begin
      if (strt_cnv === 1'b1)   strt_cnt++;
      if (sweep_done === 1'b1) sd_cnt++;
    end
    if (strt_cnv === 1'b1) begin
      cnv_cmplt = 1'b0;
      pend = 1'b1;
      cd = LAT;
      cur_ch = chnnl;
      if (chnnl != last_ch || samp_idx == 4) samp_idx = 0;
      cur_val = base[chnnl] + 12'(samp_idx);
      samp_idx++;
      last_ch = chnnl;
      if (order[3:0] != 4'({1'b0, chnnl}) + 4'd1) order = {order[27:0], 4'({1'b0, chnnl}) + 4'd1};
    end else if (pend) begin
      if (chnnl !== cur_ch) stab_err++;
      cd--;
      if (cd == 0) begin
        pend = 1'b0;
        if (!suppress[cur_ch]) begin
          res = ~cur_val;
          cnv_cmplt = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input int ch, input logic [11:0] exp, input string tag);
    rd_chnl = 3'(ch);
    #1;
    check($sformatf("%s_rd%0d", tag, ch), {20'h0, rd_data}, {20'h0, exp});
  endtask

  task automatic clr_mon();
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_strt(input int ch, input int bound, input string tag);
    int k;
    logic hit;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      hit = (strt_cnv === 1'b1) && (int'(chnnl) == ch);
    end while (!hit && k < bound);
    check({tag, "_wait"}, {31'h0, hit}, 32'h1);
  endtask

  task automatic wait_sd(input int bound, input string tag);
    int k;
    logic hit;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      hit = (sweep_done === 1'b1);
    end while (!hit && k < bound);
    check({tag, "_wait"}, {31'h0, hit}, 32'h1);
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; chnl_mask = 8'h00; err_clr = 1'b0; rd_chnl = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    check("rst_strt", {31'h0, strt_cnv}, 32'h0);
    check("rst_chnnl", {29'h0, chnnl}, 32'h0);
    check("rst_valid", {24'h0, valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_sd", {31'h0, sweep_done}, 32'h0);
    for (int i = 0; i < 8; i++) check_rd(i, 12'h000, "rst");
    rst = 1'b0;

    // Averaging on channel 0: 0x100..0x103 -> 0x101
    clr_mon();
    chnl_mask = 8'h01; en = 1'b1;
    wait_strt(0, 20, "avg_start");
    en = 1'b0; chnl_mask = 8'h00;
    wait_sd(200, "avg_done");
    repeat (SWEEP_GAP + 4) @(negedge clk);
    check("avg_strt_cnt", 32'(strt_cnt), 32'd4);
    check("avg_sd_cnt", 32'(sd_cnt), 32'd1);
    check("avg_valid", {24'h0, valid}, 32'h01);
    check("avg_err", {31'h0, err}, 32'h0);
    check_rd(0, 12'h101, "avg");

    // Timeout on channel 2, channel 3 still converted
    suppress = 8'h04;
    clr_mon();
    chnl_mask = 8'h0C; en = 1'b1;
    wait_strt(2, 20, "to_start");
    en = 1'b0; chnl_mask = 8'h00;
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_early", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("to_err_set", {31'h0, err}, 32'h1);
    wait_sd(400, "to_done");
    repeat (SWEEP_GAP + 4) @(negedge clk);
    check("to_valid", {24'h0, valid}, 32'h09);
    check("to_order", order, 32'h34);
    check("to_strt_cnt", 32'(strt_cnt), 32'd5);
    check("to_err_hold", {31'h0, err}, 32'h1);
    check_rd(2, 12'h000, "to");
    check_rd(3, 12'hABD, "to");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", {31'h0, err}, 32'h0);
    suppress = 8'h00;

    // Mask 0xA5: channels 0,2,5,7 in order, chnnl stable during each conversion
    clr_mon();
    chnl_mask = 8'hA5; en = 1'b1;
    wait_strt(0, 20, "a5_start");
    en = 1'b0; chnl_mask = 8'h00;
    wait_sd(500, "a5_done");
    repeat (SWEEP_GAP + 4) @(negedge clk);
    check("a5_order", order, 32'h1368);
    check("a5_strt_cnt", 32'(strt_cnt), 32'd16);
    check("a5_sd_cnt", 32'(sd_cnt), 32'd1);
    check("a5_stable", 32'(stab_err), 32'd0);
    check("a5_valid", {24'h0, valid}, 32'hAD);
    check_rd(0, 12'h101, "a5");
    check_rd(2, 12'h235, "a5");
    check_rd(5, 12'hFF1, "a5");
    check_rd(7, 12'h0A1, "a5");

    // Reset in the middle of a WAIT on channel 3
    clr_mon();
    chnl_mask = 8'h08; en = 1'b1;
    wait_strt(3, 20, "mr_start");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_strt", {31'h0, strt_cnv}, 32'h0);
    check("mr_chnnl", {29'h0, chnnl}, 32'h0);
    check("mr_valid", {24'h0, valid}, 32'h0);
    check("mr_err", {31'h0, err}, 32'h0);
    for (int i = 0; i < 8; i++) check_rd(i, 12'h000, "mr");
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("mr_no_strt", 32'(strt_cnt), 32'd1);
    check("mr_no_sd", 32'(sd_cnt), 32'd0);

    // Gap/restart: next strt_cnv SWEEP_GAP+2 cycles after sweep_done
    clr_mon();
    chnl_mask = 8'h01; en = 1'b1;
    wait_sd(200, "gap_sd1");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (strt_cnv !== 1'b1 && k < SWEEP_GAP + 20);
    check("gap_restart", 32'(k), 32'(SWEEP_GAP + 2));
    en = 1'b0;
    wait_sd(200, "gap_sd2");
    clr_mon();
    repeat (SWEEP_GAP + 30) @(negedge clk);
    check("gap_no_strt", 32'(strt_cnt), 32'd0);
    check("gap_valid", {24'h0, valid}, 32'h01);
    check_rd(0, 12'h101, "gap");

    // Empty mask keeps the block idle
    clr_mon();
    chnl_mask = 8'h00; en = 1'b1;
    repeat (5000) @(negedge clk);
    check("empty_strt", 32'(strt_cnt), 32'd0);
    check("empty_sd", 32'(sd_cnt), 32'd0);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
